// File: rtl/render_pkg.sv
// Shared definitions for the sprite renderer: register map, blitter states,
// CPU register payload layouts and STATUS bit positions.
package render_pkg;

  // Slave register word indices
  localparam logic [3:0] REG_DST    = 4'd1;
  localparam logic [3:0] REG_SIZE   = 4'd2;
  localparam logic [3:0] REG_SRC    = 4'd3;
  localparam logic [3:0] REG_GO     = 4'd4;
  localparam logic [3:0] REG_STATUS = 4'd5;
  localparam logic [3:0] REG_CLEAR  = 4'd6;
  localparam logic [3:0] REG_SWAP   = 4'd7;
  localparam logic [3:0] REG_KEY    = 4'd8;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_FRONT    = 1;
  localparam int unsigned STAT_SWAP     = 2;
  localparam int unsigned STAT_FCNT_LSB = 16;
  localparam int unsigned STAT_FCNT_W   = 16;

  // DST / SIZE payload: x or w in [9:0], y or h in [24:16]
  typedef struct packed {
    logic [6:0] rsvd_hi;
    logic [8:0] y;
    logic [5:0] rsvd_lo;
    logic [9:0] x;
  } xy_reg_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } blit_state_t;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame-buffer RAM: one write port, one registered read port.
module fb_ram #(
  parameter int unsigned DEPTH = 76800,
  parameter int unsigned DW    = 6,
  parameter int unsigned AW    = 17
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sprite_renderer.sv
// Double-buffered sprite renderer: CPU slave, texture read master, blitter/fill
// into the back buffer, front buffer scanned out, index-flip swap on frame wrap.
// Optional feature macro: TRANSPARENCY_EN (KEY register, keyed blit pixels skipped).
module sprite_renderer
  import render_pkg::*;
#(
  parameter int unsigned WIDTH        = 320,
  parameter int unsigned HEIGHT       = 240,
  parameter int unsigned PIX_W        = 6,
  parameter int unsigned FRAME_CYCLES = 1666666
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             slave_waitrequest,
  input  logic [3:0]       slave_address,
  input  logic             slave_read,
  output logic [31:0]      slave_readdata,
  input  logic             slave_write,
  input  logic [31:0]      slave_writedata,
  input  logic             master_waitrequest,
  output logic [31:0]      master_address,
  output logic             master_read,
  input  logic [31:0]      master_readdata,
  input  logic             master_readdatavalid,
  input  logic [9:0]       vid_x,
  input  logic [8:0]       vid_y,
  output logic [PIX_W-1:0] vid_pixel,
  output logic             frame_tick
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned CW   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  blit_state_t state, state_d;
  logic             busy;
  logic [9:0]       dst_x, size_w, col;
  logic [8:0]       dst_y, size_h, row;
  logic [31:0]      src_base;
  logic [PIX_W-1:0] clear_col;
  logic [AW-1:0]    fill_addr;
  logic             front, swap_pending;
  logic [CW-1:0]    cyc_cnt;
  logic [15:0]      frame_cnt;
`ifdef TRANSPARENCY_EN
  logic [PIX_W-1:0] key;
`endif

  assign busy = (state != IDLE);

  // Slave write decode; configuration/command writes stall while busy
  logic    stall_idx, wr_acc;
  logic    wr_dst, wr_size, wr_src, wr_go, wr_clear, wr_swap;
  xy_reg_t wr_xy;

  assign stall_idx = slave_address inside {REG_DST, REG_SIZE, REG_SRC, REG_GO, REG_CLEAR};
  assign slave_waitrequest = slave_write && stall_idx && busy;
  assign wr_acc   = slave_write && !slave_waitrequest;
  assign wr_dst   = wr_acc && (slave_address == REG_DST);
  assign wr_size  = wr_acc && (slave_address == REG_SIZE);
  assign wr_src   = wr_acc && (slave_address == REG_SRC);
  assign wr_go    = wr_acc && (slave_address == REG_GO);
  assign wr_clear = wr_acc && (slave_address == REG_CLEAR);
  assign wr_swap  = wr_acc && (slave_address == REG_SWAP);
  assign wr_xy    = xy_reg_t'(slave_writedata);

  // Blit pixel destination, clipping and keying
  logic             go_ok, last_pix, clipped, keyed;
  logic [10:0]      wx;
  logic [9:0]       wy;
  logic [PIX_W-1:0] tex_pix;

  assign go_ok    = (size_w != 10'd0) && (size_h != 9'd0);
  assign last_pix = (col == size_w - 10'd1) && (row == size_h - 9'd1);
  assign wx       = {1'b0, dst_x} + {1'b0, col};
  assign wy       = {1'b0, dst_y} + {1'b0, row};
  assign clipped  = (32'(wx) >= WIDTH) || (32'(wy) >= HEIGHT);
  assign tex_pix  = master_readdata[PIX_W-1:0];
`ifdef TRANSPARENCY_EN
  assign keyed    = (tex_pix == key);
`else
  assign keyed    = 1'b0;
`endif

  // Blitter next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (wr_clear)   state_d = FILL;
        else if (wr_go) state_d = go_ok ? REQ : DONE;
      end
      FILL:    if (fill_addr == AW'(NPIX - 1)) state_d = IDLE;
      REQ:     if (!master_waitrequest) state_d = WAIT;
      WAIT:    if (master_readdatavalid) state_d = last_pix ? IDLE : REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Back-buffer write port: fill colour or fetched texel
  logic             fb_we;
  logic [AW-1:0]    fb_waddr;
  logic [PIX_W-1:0] fb_wdata;

  always_comb begin
    fb_we    = 1'b0;
    fb_waddr = '0;
    fb_wdata = '0;
    if (state == FILL) begin
      fb_we    = 1'b1;
      fb_waddr = fill_addr;
      fb_wdata = clear_col;
    end else if ((state == WAIT) && master_readdatavalid && !clipped && !keyed) begin
      fb_we    = 1'b1;
      fb_waddr = AW'(32'(wy) * WIDTH + 32'(wx));
      fb_wdata = tex_pix;
    end
  end

  // Blitter state, walk counters and master request outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      fill_addr      <= '0;
      col            <= '0;
      row            <= '0;
      master_read    <= 1'b0;
      master_address <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: begin
          if (wr_clear) fill_addr <= '0;
          if (wr_go && go_ok) begin
            master_read    <= 1'b1;
            master_address <= src_base;
            col            <= '0;
            row            <= '0;
          end
        end
        FILL: fill_addr <= fill_addr + AW'(1);
        REQ:  if (!master_waitrequest) master_read <= 1'b0;
        WAIT: begin
          if (master_readdatavalid && !last_pix) begin
            master_read    <= 1'b1;
            master_address <= master_address + 32'd4;
            if (col == size_w - 10'd1) begin
              col <= '0;
              row <= row + 9'd1;
            end else begin
              col <= col + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_x     <= '0;
      dst_y     <= '0;
      size_w    <= '0;
      size_h    <= '0;
      src_base  <= '0;
      clear_col <= '0;
`ifdef TRANSPARENCY_EN
      key       <= '0;
`endif
    end else begin
      if (wr_dst) begin
        dst_x <= wr_xy.x;
        dst_y <= wr_xy.y;
      end
      if (wr_size) begin
        size_w <= wr_xy.x;
        size_h <= wr_xy.y;
      end
      if (wr_src)   src_base  <= slave_writedata;
      if (wr_clear) clear_col <= slave_writedata[PIX_W-1:0];
`ifdef TRANSPARENCY_EN
      if (wr_acc && (slave_address == REG_KEY)) key <= slave_writedata[PIX_W-1:0];
`endif
    end
  end

  // Frame timer, frame count and deferred buffer swap
  logic wrap;
  assign wrap = (cyc_cnt == CW'(FRAME_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt      <= '0;
      frame_cnt    <= '0;
      frame_tick   <= 1'b0;
      front        <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (wrap) begin
        cyc_cnt   <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end
      if (wrap && (swap_pending || wr_swap) && !busy) begin
        front        <= ~front;
        swap_pending <= 1'b0;
      end else if (wr_swap) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Slave read mux
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    unique case (slave_address)
      REG_DST:    rd_mux = {7'd0, dst_y, 6'd0, dst_x};
      REG_SIZE:   rd_mux = {7'd0, size_h, 6'd0, size_w};
      REG_SRC:    rd_mux = src_base;
      REG_STATUS: begin
        rd_mux[STAT_BUSY]  = busy;
        rd_mux[STAT_FRONT] = front;
        rd_mux[STAT_SWAP]  = swap_pending;
        rd_mux[STAT_FCNT_LSB +: STAT_FCNT_W] = frame_cnt;
      end
`ifdef TRANSPARENCY_EN
      REG_KEY:    rd_mux = 32'(key);
`endif
      default:    rd_mux = '0;
    endcase
  end

  // Fixed latency-1 read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slave_readdata <= '0;
    else        slave_readdata <= slave_read ? rd_mux : 32'd0;
  end

  // Display read: both buffers read the same address, front selected after the RAM
  logic             vid_ok, vid_ok_q, vid_sel_q;
  logic [AW-1:0]    vid_addr;
  logic [PIX_W-1:0] rd0, rd1;

  assign vid_ok   = (32'(vid_x) < WIDTH) && (32'(vid_y) < HEIGHT);
  assign vid_addr = AW'(32'(vid_y) * WIDTH + 32'(vid_x));

  // Range flag and buffer select aligned with the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_ok_q  <= 1'b0;
      vid_sel_q <= 1'b0;
    end else begin
      vid_ok_q  <= vid_ok;
      vid_sel_q <= front;
    end
  end

  assign vid_pixel = !vid_ok_q ? '0 : (vid_sel_q ? rd1 : rd0);

  fb_ram #(.DEPTH(NPIX), .DW(PIX_W), .AW(AW)) u_fb0 (
    .clk     (clk),
    .wr_en   (fb_we && front),
    .wr_addr (fb_waddr),
    .wr_data (fb_wdata),
    .rd_addr (vid_addr),
    .rd_data (rd0)
  );

  fb_ram #(.DEPTH(NPIX), .DW(PIX_W), .AW(AW)) u_fb1 (
    .clk     (clk),
    .wr_en   (fb_we && !front),
    .wr_addr (fb_waddr),
    .wr_data (fb_wdata),
    .rd_addr (vid_addr),
    .rd_data (rd1)
  );

  logic unused_bits;
  assign unused_bits = ^{slave_writedata, master_readdata, wr_xy.rsvd_hi, wr_xy.rsvd_lo};

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed self-checking bench for sprite_renderer on a reduced 32x24 frame.
module tb_sprite_renderer;

  localparam int unsigned W  = 32;
  localparam int unsigned H  = 24;
  localparam int unsigned PW = 6;
  localparam int unsigned FC = 2000;

  localparam logic [3:0] A_DST = 4'd1, A_SIZE = 4'd2, A_SRC = 4'd3, A_GO = 4'd4;
  localparam logic [3:0] A_STAT = 4'd5, A_CLEAR = 4'd6, A_SWAP = 4'd7, A_KEY = 4'd8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          slave_waitrequest;
  logic [3:0]    slave_address = '0;
  logic          slave_read = 1'b0;
  logic [31:0]   slave_readdata;
  logic          slave_write = 1'b0;
  logic [31:0]   slave_writedata = '0;
  logic          master_waitrequest = 1'b0;
  logic [31:0]   master_address;
  logic          master_read;
  logic [31:0]   master_readdata = '0;
  logic          master_readdatavalid = 1'b0;
  logic [9:0]    vid_x = '0;
  logic [8:0]    vid_y = '0;
  logic [PW-1:0] vid_pixel;
  logic          frame_tick;

  int total = 0;
  int bad = 0;
  int ticks = 0;
  int wait_cycles = 0;
  logic [31:0] mem_q [$];
  logic [31:0] addr_log [$];

  sprite_renderer #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .FRAME_CYCLES(FC)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .vid_x                (vid_x),
    .vid_y                (vid_y),
    .vid_pixel            (vid_pixel),
    .frame_tick           (frame_tick)
  );

  always #5 clk = ~clk;

  // Count frame_tick pulses seen since the last reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ticks <= 0;
    else if (frame_tick) ticks <= ticks + 1;
  end

  // Texture memory: stalls each request wait_cycles cycles, answers one cycle after accept
  initial begin : mem_model
    int   wcnt;
    logic acc;
    wcnt = 0;
    acc  = 1'b0;
    forever begin
      @(negedge clk);
      master_readdatavalid = 1'b0;
      if (acc) begin
        master_readdatavalid = 1'b1;
        master_readdata = (mem_q.size() > 0) ? mem_q.pop_front() : 32'd0;
        acc  = 1'b0;
        wcnt = 0;
      end else if (master_read) begin
        if (wcnt < wait_cycles) begin
          master_waitrequest = 1'b1;
          wcnt++;
        end else begin
          master_waitrequest = 1'b0;
          acc = 1'b1;
          addr_log.push_back(master_address);
        end
      end else begin
        master_waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    #1;
    while (slave_waitrequest === 1'b1 && n < 5000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL cpu_wr_timeout addr=%0d waitrequest still %b", a, slave_waitrequest);
    end
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    @(posedge clk); #1;
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  task automatic rd_pix(input int x, input int y, output logic [PW-1:0] p);
    @(negedge clk);
    vid_x = 10'(x); vid_y = 9'(y);
    @(posedge clk); #1;
    p = vid_pixel;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (frame_tick !== 1'b1 && n < 3 * FC) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3 * FC) begin
      total++; bad++;
      $display("FAIL frame_tick_timeout no pulse within %0d cycles", 3 * FC);
    end
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int n;
    n = 0;
    cpu_rd(A_STAT, s);
    while (s[0] === 1'b1 && n < 2000) begin
      cpu_rd(A_STAT, s); n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL busy_timeout status=%h still busy", s);
    end
  endtask

  task automatic test_reset;
    logic [31:0] s;
    logic [PW-1:0] p;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({slave_waitrequest, slave_readdata, master_read, master_address, vid_pixel, frame_tick} !== '0) begin
      bad++;
      $display("FAIL reset_outputs wr=%b rd=%h mr=%b ma=%h px=%h ft=%b want all zero",
               slave_waitrequest, slave_readdata, master_read, master_address, vid_pixel, frame_tick);
    end
    @(negedge clk); rst_n = 1'b1;
    cpu_rd(A_STAT, s);
    total++;
    if (s !== 32'd0) begin bad++; $display("FAIL reset_status got %h want 0", s); end
    rd_pix(1000, 0, p);
    total++;
    if (p !== '0) begin bad++; $display("FAIL reset_pix_oob got %h want 0", p); end
    total++;
    if (master_read !== 1'b0) begin bad++; $display("FAIL reset_no_read master_read=%b want 0", master_read); end
  endtask

  task automatic test_clear_swap;
    logic [31:0] s;
    logic [PW-1:0] p;
    int xs [3] = '{0, 31, 32};
    int ys [3] = '{0, 23, 0};
    logic [PW-1:0] ex [3] = '{6'h2A, 6'h2A, 6'h00};
    cpu_wr(A_CLEAR, 32'hFFFF_FF2A);
    cpu_wr(A_SWAP, 32'd0);
    cpu_rd(A_STAT, s);
    total++;
    if (s !== 32'h0000_0005) begin bad++; $display("FAIL clear_status_busy got %h want 00000005", s); end
    wait_tick();
    cpu_rd(A_STAT, s);
    total++;
    if (s !== 32'h0001_0002) begin bad++; $display("FAIL clear_status_swapped got %h want 00010002", s); end
    for (int i = 0; i < 3; i++) begin
      rd_pix(xs[i], ys[i], p);
      total++;
      if (p !== ex[i]) begin bad++; $display("FAIL clear_pix (%0d,%0d) got %h want %h", xs[i], ys[i], p, ex[i]); end
    end
  endtask

  task automatic test_blit;
    logic [PW-1:0] p;
    int xs [4] = '{10, 11, 10, 11};
    int ys [4] = '{20, 20, 21, 21};
    addr_log.delete();
    mem_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    wait_cycles = 3;
    cpu_wr(A_DST, 32'h0014_000A);
    cpu_wr(A_SIZE, 32'h0002_0002);
    cpu_wr(A_SRC, 32'h0000_1000);
    cpu_wr(A_GO, 32'd0);
    wait_idle();
    total++;
    if (addr_log.size() != 4) begin bad++; $display("FAIL blit_nreads got %0d want 4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      total++;
      if (addr_log[i] !== 32'h1000 + 32'(4 * i)) begin
        bad++; $display("FAIL blit_addr[%0d] got %h want %h", i, addr_log[i], 32'h1000 + 32'(4 * i));
      end
    end
    cpu_wr(A_SWAP, 32'd0);
    wait_tick();
    for (int i = 0; i < 4; i++) begin
      rd_pix(xs[i], ys[i], p);
      total++;
      if (p !== PW'(i + 1)) begin bad++; $display("FAIL blit_pix (%0d,%0d) got %h want %h", xs[i], ys[i], p, PW'(i + 1)); end
    end
  endtask

  task automatic test_clip;
    logic [PW-1:0] p;
    int xs [4] = '{31, 31, 30, 0};
    int ys [4] = '{22, 23, 22, 23};
    logic [PW-1:0] ex [4] = '{6'h07, 6'h09, 6'h2A, 6'h2A};
    addr_log.delete();
    mem_q = '{32'hFFFF_FF07, 32'd8, 32'd9, 32'd10};
    wait_cycles = 0;
    cpu_wr(A_DST, 32'h0016_001F);
    cpu_wr(A_SIZE, 32'h0002_0002);
    cpu_wr(A_SRC, 32'h0000_2000);
    cpu_wr(A_GO, 32'd0);
    wait_idle();
    total++;
    if (addr_log.size() != 4) begin bad++; $display("FAIL clip_nreads got %0d want 4", addr_log.size()); end
    else begin
      total++;
      if (addr_log[3] !== 32'h200C) begin bad++; $display("FAIL clip_last_addr got %h want 0000200c", addr_log[3]); end
    end
    cpu_wr(A_SWAP, 32'd0);
    wait_tick();
    for (int i = 0; i < 4; i++) begin
      rd_pix(xs[i], ys[i], p);
      total++;
      if (p !== ex[i]) begin bad++; $display("FAIL clip_pix (%0d,%0d) got %h want %h", xs[i], ys[i], p, ex[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] s;
    int n;
    logic saw_tick;
    wait_tick();
    repeat (FC - 60) @(posedge clk);
    wait_cycles = 30;
    mem_q = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17, 32'd18};
    cpu_wr(A_SIZE, 32'h0001_0004);
    cpu_wr(A_DST, 32'd0);
    cpu_wr(A_SRC, 32'h0000_4000);
    cpu_wr(A_GO, 32'd0);
    @(negedge clk);
    slave_address = A_SWAP; slave_writedata = 32'd0; slave_write = 1'b1;
    #1;
    total++;
    if (slave_waitrequest !== 1'b0) begin bad++; $display("FAIL swap_no_stall waitrequest=%b want 0", slave_waitrequest); end
    @(posedge clk); #1; slave_write = 1'b0;
    @(negedge clk);
    slave_address = A_GO; slave_write = 1'b1;
    #1;
    total++;
    if (slave_waitrequest !== 1'b1) begin bad++; $display("FAIL go_stall waitrequest=%b want 1", slave_waitrequest); end
    n = 0;
    saw_tick = 1'b0;
    while (slave_waitrequest === 1'b1 && n < 1000) begin
      @(negedge clk); #1;
      if (frame_tick === 1'b1) saw_tick = 1'b1;
      n++;
    end
    total++;
    if (n >= 1000) begin bad++; $display("FAIL go_stall_release waitrequest stuck after %0d cycles", n); end
    @(posedge clk); #1; slave_write = 1'b0;
    total++;
    if (saw_tick !== 1'b1) begin bad++; $display("FAIL wrap_during_blit saw_tick=%b want 1", saw_tick); end
    cpu_rd(A_STAT, s);
    total++;
    if (s[2:0] !== 3'b111) begin bad++; $display("FAIL swap_deferred status[2:0]=%b want 111", s[2:0]); end
    wait_tick();
    cpu_rd(A_STAT, s);
    total++;
    if (s[2:0] !== 3'b000) begin bad++; $display("FAIL swap_taken status[2:0]=%b want 000", s[2:0]); end
  endtask

  task automatic test_transparency;
    logic [31:0] s;
    logic [PW-1:0] p;
    logic [31:0] key_exp;
    logic [PW-1:0] pix0_exp;
`ifdef TRANSPARENCY_EN
    key_exp  = 32'h15;
    pix0_exp = 6'h3F;
`else
    key_exp  = 32'h0;
    pix0_exp = 6'h00;
`endif
    cpu_wr(A_KEY, 32'h15);
    cpu_rd(A_KEY, s);
    total++;
    if (s !== key_exp) begin bad++; $display("FAIL key_readback got %h want %h", s, key_exp); end
    cpu_wr(A_KEY, 32'd0);
    cpu_wr(A_CLEAR, 32'h3F);
    wait_idle();
    wait_cycles = 1;
    mem_q = '{32'd0, 32'd5};
    cpu_wr(A_DST, 32'h0004_0004);
    cpu_wr(A_SIZE, 32'h0001_0002);
    cpu_wr(A_SRC, 32'h0000_3000);
    cpu_wr(A_GO, 32'd0);
    wait_idle();
    cpu_wr(A_SWAP, 32'd0);
    wait_tick();
    rd_pix(4, 4, p);
    total++;
    if (p !== pix0_exp) begin bad++; $display("FAIL key_pix0 got %h want %h", p, pix0_exp); end
    rd_pix(5, 4, p);
    total++;
    if (p !== 6'h05) begin bad++; $display("FAIL key_pix1 got %h want 05", p); end
    rd_pix(6, 4, p);
    total++;
    if (p !== 6'h3F) begin bad++; $display("FAIL key_bg got %h want 3f", p); end
    cpu_rd(A_STAT, s);
    total++;
    if (s[31:16] !== 16'(ticks)) begin bad++; $display("FAIL frame_count got %0d want %0d", s[31:16], ticks); end
  endtask

  task automatic test_zero_size;
    logic [31:0] s;
    cpu_rd(A_DST, s);
    total++;
    if (s !== 32'h0004_0004) begin bad++; $display("FAIL dst_readback got %h want 00040004", s); end
    cpu_rd(4'd0, s);
    total++;
    if (s !== 32'd0) begin bad++; $display("FAIL unmapped0 got %h want 0", s); end
    cpu_rd(4'd9, s);
    total++;
    if (s !== 32'd0) begin bad++; $display("FAIL unmapped9 got %h want 0", s); end
    addr_log.delete();
    cpu_wr(A_SIZE, 32'h0001_0000);
    cpu_wr(A_GO, 32'd0);
    cpu_rd(A_STAT, s);
    total++;
    if (s[0] !== 1'b1) begin bad++; $display("FAIL zero_done_busy busy=%b want 1", s[0]); end
    cpu_rd(A_STAT, s);
    total++;
    if (s[0] !== 1'b0) begin bad++; $display("FAIL zero_idle busy=%b want 0", s[0]); end
    repeat (4) @(posedge clk);
    total++;
    if (addr_log.size() != 0) begin bad++; $display("FAIL zero_no_reads got %0d reads want 0", addr_log.size()); end
  endtask

  task automatic test_reset_mid_blit;
    logic [31:0] s;
    wait_cycles = 50;
    mem_q.delete();
    cpu_wr(A_SIZE, 32'h0002_0002);
    cpu_wr(A_GO, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (master_read !== 1'b1) begin bad++; $display("FAIL midblit_read master_read=%b want 1", master_read); end
    @(negedge clk); rst_n = 1'b0;
    #1;
    total++;
    if (master_read !== 1'b0 || master_address !== 32'd0) begin
      bad++; $display("FAIL midblit_reset master_read=%b addr=%h want 0/0", master_read, master_address);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    wait_cycles = 0;
    cpu_rd(A_STAT, s);
    total++;
    if (s !== 32'd0) begin bad++; $display("FAIL midblit_status got %h want 0", s); end
  endtask

  initial begin
    test_reset();
    test_clear_swap();
    test_blit();
    test_clip();
    test_back_to_back();
    test_transparency();
    test_zero_size();
    test_reset_mid_blit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
